// File: rtl/md5_match_ctrl.sv
// md5_match_ctrl: issues candidates into md5core and matches digests.
// Optional MD5_HASH_COUNT_EN adds a saturating compared-digest counter.
module md5_match_ctrl #(
  parameter int INFLIGHT_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] target,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [151:0] msg_data,
  input  logic         msg_last,
  output logic         core_en,
  output logic         core_valid_in,
  output logic [151:0] core_mesg,
  input  logic [31:0]  core_a,
  input  logic [31:0]  core_b,
  input  logic [31:0]  core_c,
  input  logic [31:0]  core_d,
  input  logic [151:0] core_m_out,
  input  logic         core_valid_out,
`ifdef MD5_HASH_COUNT_EN
  output logic [31:0]  hash_count,
`endif
  output logic         busy,
  output logic         done,
  output logic         match,
  output logic [151:0] match_mesg
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE,
    FLUSH
  } state_t;

  state_t state, state_nx;

  logic [127:0]          target_q;
  logic [INFLIGHT_W-1:0] inflight;
  logic                  accept;
  logic                  cmp;
  logic                  hit;
  logic                  go;
  logic                  empty;

  assign accept  = msg_valid && msg_ready;
  assign cmp     = core_valid_out && (state == RUN || state == DRAIN);
  assign hit     = cmp && ({core_a, core_b, core_c, core_d} == target_q);
  assign go      = start && (state == IDLE || state == DONE);
  assign empty   = (inflight == '0);
  assign core_en = !reset;
  assign done    = (state == DONE);

  // Next-state and handshake outputs; a match wins over msg_last.
  always_comb begin
    state_nx  = state;
    msg_ready = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = RUN;
      end
      RUN: begin
        msg_ready = 1'b1;
        if (hit) state_nx = DONE;
        else if (accept && msg_last) state_nx = DRAIN;
      end
      DRAIN: begin
        if (hit || empty) state_nx = DONE;
      end
      DONE: begin
        busy = 1'b0;
        if (start) state_nx = empty ? RUN : FLUSH;
      end
      FLUSH: begin
        if (empty) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Target latch on an accepted start.
  always_ff @(posedge clk) begin
    if (reset)   target_q <= '0;
    else if (go) target_q <= target;
  end

  // In-flight count: issue adds one, a returning digest removes one.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else if (accept && !core_valid_out) begin
      inflight <= inflight + INFLIGHT_W'(1);
    end else if (!accept && core_valid_out) begin
      inflight <= inflight - INFLIGHT_W'(1);
    end
  end

  // Registered issue into the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_valid_in <= 1'b0;
      core_mesg     <= '0;
    end else begin
      core_valid_in <= accept;
      if (accept) core_mesg <= msg_data;
    end
  end

  // Result capture; cleared when a new search is accepted.
  always_ff @(posedge clk) begin
    if (reset || go) begin
      match      <= 1'b0;
      match_mesg <= '0;
    end else if (hit) begin
      match      <= 1'b1;
      match_mesg <= core_m_out;
    end
  end

`ifdef MD5_HASH_COUNT_EN
  // Saturating count of digests compared during a search.
  always_ff @(posedge clk) begin
    if (reset || go) hash_count <= '0;
    else if (cmp && !(&hash_count)) hash_count <= hash_count + 32'd1;
  end
`endif

endmodule

// File: doc/md5_match_ctrl.md
# md5_match_ctrl

Sequencing controller for the pipelined `md5core` hash engine in the search datapath. It accepts a stream of 19-byte candidate messages from the upstream generator and issues one per cycle into `md5core`. It tracks how many messages are in flight and compares every digest leaving the core against a loaded 128-bit target. It stops on the first match and reports the matching message, or reports "no match" once the stream has been issued and the pipeline has drained.

## Interface
Parameters:
- `INFLIGHT_W`, default 8: width of the in-flight counter; must hold the maximum `md5core` pipeline occupancy (≤ 2^INFLIGHT_W − 1).

Ports:
- Clock and reset (already decided): one clock, `clk`; reset is `reset`, synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a search; sampled only in IDLE or DONE.
- `target`  in  128  target digest {a,b,c,d}; latched on an accepted `start`.
- `msg_valid`  in  1  upstream candidate valid.
- `msg_ready`  out  1  controller accepts a candidate this cycle.
- `msg_data`  in  152  candidate message, big-endian byte order.
- `msg_last`  in  1  marks the final candidate of the stream.
- `core_en`  out  1  `md5core` enable.
- `core_valid_in`  out  1  `md5core` `valid_in`.
- `core_mesg`  out  152  message field of `md5core` `m_in` (padding and length are constant, outside this block).
- `core_a`, `core_b`, `core_c`, `core_d`  in  32 each  `md5core` digest outputs.
- `core_m_out`  in  152  `md5core` message pass-through.
- `core_valid_out`  in  1  `md5core` `valid_out`.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  search finished; level, held until the next accepted `start`.
- `match`  out  1  valid when `done`; 1 means the target was found.
- `match_mesg`  out  152  message whose digest equalled `target`; valid when `done && match`.

## Operation
States:
- IDLE: after reset. On `start`, latch `target`, then go to RUN.
- RUN: `msg_ready = 1`. Each accepted beat (`msg_valid && msg_ready`) is issued to the core.
  - Accepting `msg_last` → DRAIN.
  - A match → DONE; this takes precedence over `msg_last` in the same cycle.
- DRAIN: `msg_ready = 0`.
  - A match → DONE with `match = 1`.
  - `inflight == 0` with no match → DONE with `match = 0`.
- DONE: `done = 1`. Digests still leaving the core are discarded, not compared, but they still decrement `inflight`.
  - On `start`: latch `target`, clear `done`, `match` and `match_mesg`, then go to FLUSH if `inflight != 0`, else to RUN.
- FLUSH: `msg_ready = 0`. Returning digests are discarded. On `inflight == 0` → RUN.

Rules:
- Match condition: `core_valid_out && {core_a,core_b,core_c,core_d} == target_q`, evaluated only in RUN or DRAIN.
- In-flight counter: +1 on issue, −1 on `core_valid_out`, unchanged when both happen in the same cycle. It never wraps; overflow is outside the valid operating range.
- `core_en` is 0 while `reset` is high and 1 at all other times.
- `start` in RUN, DRAIN or FLUSH is ignored.
- Reset mid-search returns to IDLE immediately and zeroes `inflight`. The core is reset by the same `reset`, so no stale results remain.

## Timing
- Reset values: `msg_ready`=0, `core_en`=0, `core_valid_in`=0, `core_mesg`=0, `busy`=0, `done`=0, `match`=0, `match_mesg`=0.
- Issue latency: a beat accepted at edge N appears on `core_valid_in`/`core_mesg` after edge N (registered). `core_valid_in` is 0 in any cycle with no accept.
- Match latency: a matching `core_valid_out` sampled at edge M sets `done`, `match` and `match_mesg` after edge M (one register stage).
- `msg_ready` can drop in the cycle immediately after a match.
- No-match completion: `done` rises one cycle after `inflight` reaches 0 in DRAIN.
- Throughput: one candidate per clock in RUN, with no bubbles.

## Configuration
- `MD5_HASH_COUNT_EN` defined:
  - Adds output `hash_count`, 32 bits, reset 0, cleared on an accepted `start`.
  - It increments on every digest compared in RUN/DRAIN and saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Load target `a2004f37_730b9445_670a738f_a0fc9ee5`. Stream "Hello World 1234567", "The quick brown fox", "This is a test. 123" (last) back-to-back.
  - → `done=1`, `match=1`, `match_mesg` = "The quick brown fox".
  - → `msg_ready` drops after the match.
- Load target `caea4868_5020e1b5_11a454f6_60943eaa`. Stream only the first two messages above, with `msg_last` on the 2nd.
  - → `done=1`, `match=0` one cycle after the pipeline empties.
  - → with `MD5_HASH_COUNT_EN`, `hash_count=2`.
- After the first test's early match, pulse `start` again.
  - → FLUSH is entered while `inflight=1`, RUN is reached once it hits 0, and the third digest is never reported as a match.
- Drive `msg_valid` every other cycle while the core returns digests.
  - → `inflight` stays correct on simultaneous issue and return, and the final `done` timing matches the pipeline depth.
- Assert `reset` while in DRAIN with messages in flight.
  - → all outputs take their reset values at the next edge, and the state is IDLE.
- Pulse `start` while in RUN.
  - → ignored; `target_q` is unchanged and the search completes normally.
